// File: rtl/keypad_debounce_encoder_if.sv
// Keypad bus: raw one-hot key lines in, debounced digit / strobe / status out.
// master = encoder side, slave = keypad driver + downstream consumer side.
interface keypad_debounce_encoder_if;
  logic [9:0] key_raw;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       key_err;

  modport master (input key_raw, output key_code, key_valid, key_held, key_err);
  modport slave  (output key_raw, input key_code, key_valid, key_held, key_err);
endinterface

// File: rtl/keypad_debounce_encoder.sv
// Synchronise, debounce and encode a 10-key one-hot keypad into a digit plus one-cycle strobe.
// Optional multi-key error flag is built only when MULTIKEY_ERR_EN is defined.
module keypad_debounce_encoder #(
  parameter int DEB_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  keypad_debounce_encoder_if.master        kp
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // The capture cycle in IDLE is the first stable sample, so DEBOUNCE fires one count early.
  localparam logic [CNT_W-1:0] CNT_PRESS = CNT_W'(DEB_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_REL   = CNT_W'(DEB_CYCLES - 1);

  function automatic logic is_onehot(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [3:0] encode(input logic [9:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  logic [9:0]       sync1_q;
  logic [9:0]       sync2_q;
  logic [1:0]       sync_vld_q;
  logic             armed_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [9:0]       cap_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;

  logic [9:0] s;
  logic       s_vld;
  logic       s_onehot;

  assign s        = sync2_q;
  assign s_vld    = sync_vld_q[1];
  assign s_onehot = is_onehot(s);

  // Two-flop synchroniser; sync_vld_q marks when s carries real keypad samples after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 10'd0;
      sync2_q    <= 10'd0;
      sync_vld_q <= 2'b00;
    end else begin
      sync1_q    <= kp.key_raw;
      sync2_q    <= sync1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  // Press/release FSM with registered strobe, code and held outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      cap_q       <= 10'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          key_held_q <= 1'b0;
          // A key held through reset must be released before it can be accepted.
          if (!armed_q) begin
            if (s_vld && (s == 10'd0)) begin
              armed_q <= 1'b1;
            end
          end else if (s_onehot) begin
            cap_q   <= s;
            cnt_q   <= '0;
            state_q <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          key_held_q <= 1'b0;
          if (s == cap_q) begin
            if (cnt_q == CNT_PRESS) begin
              state_q     <= PRESSED;
              key_valid_q <= 1'b1;
              key_code_q  <= encode(cap_q);
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (s_onehot) begin
            cap_q <= s;
            cnt_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        PRESSED: begin
          if (s != cap_q) begin
            state_q    <= RELEASE;
            cnt_q      <= '0;
            key_held_q <= 1'b0;
          end else begin
            key_held_q <= 1'b1;
          end
        end
        RELEASE: begin
          key_held_q <= 1'b0;
          if (s == 10'd0) begin
            if (cnt_q == CNT_REL) begin
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= IDLE;
          key_held_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef MULTIKEY_ERR_EN
  logic key_err_q;

  // Multi-key level flag, independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_err_q <= 1'b0;
    end else begin
      key_err_q <= (s != 10'd0) && !s_onehot;
    end
  end

  assign kp.key_err = key_err_q;
`else
  assign kp.key_err = 1'b0;
`endif

  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Directed + randomised bench for keypad_debounce_encoder (DEB_CYCLES=4) against a run-length model.
module tb_keypad_debounce_encoder;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst_n;

  keypad_debounce_encoder_if kp ();

  keypad_debounce_encoder #(.DEB_CYCLES(DEB), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: keypad samples reach the decision logic two edges late.
  logic [10:0] pipe[$];
  bit          m_armed;
  int          m_mode;      // 0 looking for a press, 1 key held, 2 waiting for clean release
  int          m_run_len;
  int          m_zero_run;
  logic [9:0]  m_run_val;
  logic [3:0]  m_code;
  logic        e_valid, e_held, e_err;

  int seg_edge, strobes, strobe_at;

  function automatic int digit_of(input logic [9:0] v);
    int d;
    d = 0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) d = i;
    end
    return d;
  endfunction

  task automatic model_reset();
    pipe.delete();
    pipe.push_back(11'd0);
    pipe.push_back(11'd0);
    m_armed    = 1'b0;
    m_mode     = 0;
    m_run_len  = 0;
    m_zero_run = 0;
    m_run_val  = 10'd0;
    m_code     = 4'd0;
  endtask

  task automatic model_edge(input logic [9:0] raw);
    logic [10:0] smp;
    logic [9:0]  s;
    bit          sv, was_holding;
    smp = pipe.pop_front();
    pipe.push_back({1'b1, raw});
    sv = smp[10];
    s  = smp[9:0];
    e_valid     = 1'b0;
    was_holding = (m_mode == 1);
`ifdef MULTIKEY_ERR_EN
    e_err = (s != 10'd0) && ($countones(s) != 1);
`else
    e_err = 1'b0;
`endif
    if (m_mode == 0) begin
      if (!m_armed) begin
        if (sv && s == 10'd0) m_armed = 1'b1;
      end else if ($countones(s) == 1) begin
        if (m_run_len > 0 && s == m_run_val) m_run_len++;
        else begin
          m_run_val = s;
          m_run_len = 1;
        end
        if (m_run_len == DEB) begin
          e_valid   = 1'b1;
          m_code    = 4'(digit_of(s));
          m_mode    = 1;
          m_run_len = 0;
        end
      end else begin
        m_run_len = 0;
      end
    end else if (m_mode == 1) begin
      if (s != (10'd1 << m_code)) begin
        m_mode     = 2;
        m_zero_run = 0;
      end
    end else begin
      if (s == 10'd0) begin
        m_zero_run++;
        if (m_zero_run == DEB) begin
          m_mode    = 0;
          m_run_len = 0;
        end
      end else begin
        m_zero_run = 0;
      end
    end
    e_held = was_holding && (m_mode == 1);
  endtask

  task automatic check_bits(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic seg_begin();
    seg_edge  = 0;
    strobes   = 0;
    strobe_at = -1;
  endtask

  task automatic step(input logic [9:0] raw);
    kp.key_raw = raw;
    @(posedge clk);
    #1;
    seg_edge++;
    if (kp.key_valid === 1'b1) begin
      strobes++;
      strobe_at = seg_edge;
    end
    model_edge(raw);
    check_bits("key_valid", {3'b000, kp.key_valid}, {3'b000, e_valid});
    check_bits("key_held",  {3'b000, kp.key_held},  {3'b000, e_held});
    check_bits("key_err",   {3'b000, kp.key_err},   {3'b000, e_err});
    check_bits("key_code",  kp.key_code, m_code);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_bits({tag, "_valid"}, {3'b000, kp.key_valid}, 4'd0);
    check_bits({tag, "_held"},  {3'b000, kp.key_held},  4'd0);
    check_bits({tag, "_err"},   {3'b000, kp.key_err},   4'd0);
    check_bits({tag, "_code"},  kp.key_code, 4'd0);
  endtask

  initial begin
    logic [9:0] pat;
    int         kind, len, a, b;

    rst_n      = 1'b0;
    kp.key_raw = 10'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    #2 rst_n = 1'b1;
    repeat (8) step(10'd0);

    // Clean press of digit 2.
    seg_begin();
    repeat (10) step(10'h004);
    repeat (10) step(10'd0);
    check_int("clean_strobes", strobes, 1);
    check_int("clean_latency", strobe_at, 6);
    check_bits("clean_code", kp.key_code, 4'd2);

    // Bounce on digit 5, then hold.
    seg_begin();
    for (int i = 0; i < 6; i++) step(i[0] ? 10'h020 : 10'd0);
    repeat (10) step(10'h020);
    repeat (10) step(10'd0);
    check_int("bounce_strobes", strobes, 1);
    check_int("bounce_latency", strobe_at, 11);
    check_bits("bounce_code", kp.key_code, 4'd5);

    // Sequence 2,5,8,1.
    seg_begin();
    repeat (8) step(10'h004);
    repeat (8) step(10'd0);
    repeat (8) step(10'h020);
    repeat (8) step(10'd0);
    repeat (8) step(10'h100);
    repeat (8) step(10'd0);
    repeat (8) step(10'h002);
    repeat (8) step(10'd0);
    check_int("seq_strobes", strobes, 4);
    check_bits("seq_code", kp.key_code, 4'd1);

    // Slide from 8 to 1 without release.
    seg_begin();
    repeat (10) step(10'h100);
    repeat (10) step(10'h002);
    repeat (10) step(10'd0);
    check_int("slide_strobes", strobes, 1);
    check_bits("slide_code", kp.key_code, 4'd8);

    // Two keys at once.
    seg_begin();
    repeat (10) step(10'h003);
    repeat (10) step(10'd0);
    check_int("multi_strobes", strobes, 0);

    // Reset at the third stable cycle of digit 7.
    seg_begin();
    repeat (5) step(10'h080);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    seg_begin();
    repeat (10) step(10'h080);
    check_int("held_after_reset_strobes", strobes, 0);
    repeat (10) step(10'd0);
    seg_begin();
    repeat (10) step(10'h080);
    repeat (10) step(10'd0);
    check_int("repress_strobes", strobes, 1);
    check_bits("repress_code", kp.key_code, 4'd7);

    // Randomised segments of presses, bounces, multi-key and idle.
    for (int seg = 0; seg < 60; seg++) begin
      kind = $urandom_range(0, 5);
      len  = $urandom_range(1, 12);
      a    = $urandom_range(0, 9);
      b    = (a + 1 + $urandom_range(0, 8)) % 10;
      pat  = 10'd1 << a;
      for (int c = 0; c < len; c++) begin
        case (kind)
          0:       step(10'd0);
          4:       step(pat | (10'd1 << b));
          5:       step(($urandom_range(0, 1) == 0) ? 10'd0 : pat);
          default: step(pat);
        endcase
      end
    end
    repeat (12) step(10'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
